// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
// The granted word is captured in a registered valid/ready output stage.
// The output register accepts a new word in the same edge as the old one is
// consumed, so a continuously ready consumer sees one word per cycle.
module rr_mux4_arbiter #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [SIZE-1:0]  d0,
    input  logic [SIZE-1:0]  d1,
    input  logic [SIZE-1:0]  d2,
    input  logic [SIZE-1:0]  d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_data,
    output logic [1:0]       out_src,
    output logic [CNT_W-1:0] xfer_count
);

    logic [1:0]      ptr;
    logic            space;
    logic            load;
    logic            accept;
    logic [1:0]      winner;
    logic [1:0]      idx;
    logic            found;
    logic [SIZE-1:0] mux_data;

    // The output register can take a word if it is empty or being drained
    // this cycle. Holding rst_n low forces gnt/sel to zero without an edge.
    assign space  = !out_valid || out_ready;
    assign load   = rst_n && space && (|req);
    assign accept = out_valid && out_ready;

    // Search upward from the slot after the last grant, wrapping at 3.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Grant and select are only asserted when a load actually happens.
    always_comb begin
        gnt = 4'b0000;
        sel = 2'd0;
        if (load) begin
            sel = winner;
            gnt = 4'b0001 << winner;
        end
    end

    // Combinational 4:1 mux; sel is 0 when idle, so no X leaks from d[sel].
    always_comb begin
        mux_data = d0;
        case (sel)
            2'd0: mux_data = d0;
            2'd1: mux_data = d1;
            2'd2: mux_data = d2;
            2'd3: mux_data = d3;
            default: mux_data = d0;
        endcase
    end

    // Output register, round-robin pointer and accepted-transfer counter.
    // ptr resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 2'd0;
            ptr        <= 2'd3;
            xfer_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_src   <= sel;
                ptr       <= sel;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: table-driven grant vectors plus hand-written
// backpressure, reset and counter-wrap sequences, with a scoreboard queue
// holding the words expected to come out of the output register.
module tb_rr_mux4_arbiter;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [SIZE-1:0]  dv [4];
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [SIZE-1:0]  out_data;
    logic [1:0]       out_src;
    logic [CNT_W-1:0] xfer_count;

    rr_mux4_arbiter #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .d0         (dv[0]),
        .d1         (dv[1]),
        .d2         (dv[2]),
        .d3         (dv[3]),
        .gnt        (gnt),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] data;
        logic [1:0]      src;
    } word_t;

    typedef struct {
        logic [3:0] req;
        logic       ready;
        logic [3:0] exp_gnt;
    } vec_t;

    word_t           sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [1:0]      m_ptr;
    logic            m_valid;
    logic [CNT_W-1:0] m_cnt;
    logic [3:0]      last_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference priority pick: first requester at (p+1+k) mod 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (int'(p) + 1 + k) % 4;
            if (r[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_ptr   = 2'd3;
        m_valid = 1'b0;
        m_cnt   = '0;
    endtask

    // One cycle: inputs are already driven; check at the falling edge,
    // update the model, then step past the next rising edge.
    task automatic tick();
        logic       ld;
        logic [1:0] w;
        logic [3:0] eg;
        @(negedge clk);
        ld = (!m_valid || out_ready) && (|req);
        w  = pick(req, m_ptr);
        eg = ld ? (4'b0001 << w) : 4'b0000;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("sel", 64'(sel), ld ? 64'(w) : 64'd0);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                chk("out_data", 64'(out_data), 64'(sb[0].data));
                chk("out_src", 64'(out_src), 64'(sb[0].src));
            end
        end
        last_gnt = gnt;
        if (m_valid && out_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (ld) begin
            sb.push_back('{data: dv[w], src: w});
            m_ptr   = w;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs [10];
    logic [SIZE-1:0] held;

    initial begin
        vecs[0] = '{4'b1111, 1'b1, 4'b0001};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010};
        vecs[2] = '{4'b1111, 1'b1, 4'b0100};
        vecs[3] = '{4'b1111, 1'b1, 4'b1000};
        vecs[4] = '{4'b1111, 1'b1, 4'b0001};
        vecs[5] = '{4'b0000, 1'b1, 4'b0000};
        vecs[6] = '{4'b0100, 1'b1, 4'b0100};
        vecs[7] = '{4'b0011, 1'b1, 4'b0001};
        vecs[8] = '{4'b0001, 1'b1, 4'b0001};
        vecs[9] = '{4'b0000, 1'b1, 4'b0000};

        dv[0] = 32'hA0A0_0000;
        dv[1] = 32'hB1B1_1111;
        dv[2] = 32'hDEAD_BEEF;
        dv[3] = 32'hC3C3_3333;
        do_reset();

        // Reset state visible before any load.
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_xfer_count", 64'(xfer_count), 64'd0);

        // Rotation, single request, skip and wrap vectors.
        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req;
            out_ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_gnt", i), 64'(last_gnt), 64'(vecs[i].exp_gnt));
            if (i == 6) chk("t2_out_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
            if (i == 6) chk("t2_out_src", 64'(out_src), 64'd2);
        end

        // Backpressure: load one word, then hold out_ready low for 3 cycles.
        req = 4'b0011;
        out_ready = 1'b0;
        tick();
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_gnt_zero", 64'(last_gnt), 64'd0);
            chk("bp_data_stable", 64'(out_data), 64'(held));
        end
        begin
            logic [CNT_W-1:0] c0;
            c0 = xfer_count;
            out_ready = 1'b1;
            tick();
            chk("bp_release_gnt", 64'(last_gnt), 64'b0001);
            chk("bp_count_inc", 64'(xfer_count), 64'(c0 + 1'b1));
        end

        // Asynchronous reset mid-run with a word held: effect without an edge.
        out_ready = 1'b0;
        req = 4'b1111;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_out_data", 64'(out_data), 64'd0);
        chk("t1_xfer_count", 64'(xfer_count), 64'd0);
        chk("t1_gnt", 64'(gnt), 64'd0);
        chk("t1_sel", 64'(sel), 64'd0);
        do_reset();

        // Counter wrap: 16 accepted transfers bring a 4-bit count back to 0.
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("t6_count_wrap", 64'(xfer_count), 64'd0);

        // Random stream against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            for (int j = 0; j < 4; j++) dv[j] = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
